// File: rtl/regfile_mp.sv
// Multi-port integer register file with a hardwired-zero x0 and two prioritised write
// ports. Carries an issue scoreboard that flags registers waiting on an in-flight producer.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_pending,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                busy_any
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             wr0_en;
  logic             wr1_en;
  logic             iss_en;

  // Address 0 is never a legal destination, so it is filtered out once here.
  assign wr0_en = we0 && (wa0 != '0);
  assign wr1_en = we1 && (wa1 != '0);
  assign iss_en = iss_valid && (iss_rd != '0);

  // Clears first and then the issue set, so a new producer supersedes a retiring one.
  always_comb begin
    pend_nxt = pend;
    if (wr0_en) pend_nxt[wa0] = 1'b0;
    if (wr1_en) pend_nxt[wa1] = 1'b0;
    if (iss_en) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      pend <= '0;
    end else begin
      if (wr0_en) regs[wa0] <= wd0;
      if (wr1_en) regs[wa1] <= wd1;
      pend <= pend_nxt;
    end
  end

  assign busy_any = |pend;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] rdata;
    logic            rpend;

    assign ra   = rs_addr[p*AW +: AW];
    assign hit0 = wr0_en && (wa0 == ra);
    assign hit1 = wr1_en && (wa1 == ra);

    // Outputs are forced to 0 during reset so bypassed write data cannot leak through.
    always_comb begin
      rdata = regs[ra];
      rpend = pend[ra];
      if (BYPASS != 0) begin
        if (hit1) begin
          rdata = wd1;
        end else if (hit0) begin
          rdata = wd0;
        end
        if ((hit0 || hit1) && !(iss_en && (iss_rd == ra))) begin
          rpend = 1'b0;
        end
      end
      if ((ra == '0) || !rst_n) begin
        rdata = '0;
        rpend = 1'b0;
      end
    end

    assign rs_data[p*XLEN +: XLEN] = rdata;
    assign rs_pending[p]           = rpend;
  end

endmodule
